// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: shared-counter multi-channel PWM with double-buffered period/duty; wrap status and irq exist only when PWM_IRQ_EN is defined
module pwm_multi_channel #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [7:0]          addr,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         wdata,
  output logic                ready,
  output logic [31:0]         rdata,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq
);
  logic                access, wr, wrap, ld, irq_en, wrap_flag, unused_addr;
  logic [5:0]          word;
  logic [31:0]         rd_val;
  logic                ready_q, ready_d, en_q, en_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [CHANNELS-1:0] pol_q, pol_d, pwm_q, pwm_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, period_s_q, period_s_d, period_a_q, period_a_d;
  logic [CNT_W-1:0]    duty_s_q [CHANNELS];
  logic [CNT_W-1:0]    duty_s_d [CHANNELS];
  logic [CNT_W-1:0]    duty_a_q [CHANNELS];
  logic [CNT_W-1:0]    duty_a_d [CHANNELS];

  function automatic logic [CNT_W-1:0] merge(input logic [CNT_W-1:0] cur, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return CNT_W'((32'(cur) & ~m) | (d & m));
  endfunction

  assign word        = addr[7:2];
  assign unused_addr = ^addr[1:0];
  assign access      = valid & ~ready_q;
  assign wr          = access & (wstrb != 4'd0);
  assign wrap        = en_q & (cnt_q == period_a_q);
  assign ld          = wrap | ~en_q;
  assign ready       = ready_q;
  assign rdata       = rdata_q;
  assign pwm_out     = pwm_q;

  // register read mux; shadows are what the bus sees
  always_comb begin
    rd_val = 32'd0;
    if (word == 6'd0) rd_val = (32'(pol_q) << 8) | {30'd0, irq_en, en_q};
    if (word == 6'd1) rd_val = 32'(period_s_q);
    if (word == 6'd2) rd_val = 32'(cnt_q);
    if (word == 6'd3) rd_val = {31'd0, wrap_flag};
    for (int i = 0; i < CHANNELS; i++) if (word == 6'(4 + i)) rd_val = 32'(duty_s_q[i]);
  end

  // next state: bus handshake, shadow writes, active reload at wrap or while idle, counter and outputs
  always_comb begin
    ready_d    = access;
    rdata_d    = access ? rd_val : 32'd0;
    en_d       = (wr && word == 6'd0 && wstrb[0]) ? wdata[0] : en_q;
    pol_d      = (wr && word == 6'd0 && wstrb[1]) ? wdata[8 +: CHANNELS] : pol_q;
    period_s_d = (wr && word == 6'd1) ? merge(period_s_q, wstrb, wdata) : period_s_q;
    period_a_d = ld ? period_s_q : period_a_q;
    cnt_d      = ld ? '0 : cnt_q + 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_s_d[i] = (wr && word == 6'(4 + i)) ? merge(duty_s_q[i], wstrb, wdata) : duty_s_q[i];
      duty_a_d[i] = ld ? duty_s_q[i] : duty_a_q[i];
      pwm_d[i]    = (en_q & (cnt_q < duty_a_q[i])) ^ pol_q[i];
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      en_q       <= 1'b0;
      pol_q      <= '0;
      period_s_q <= '0;
      period_a_q <= '0;
      cnt_q      <= '0;
      pwm_q      <= '0;
      duty_s_q   <= '{default: '0};
      duty_a_q   <= '{default: '0};
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      pol_q      <= pol_d;
      period_s_q <= period_s_d;
      period_a_q <= period_a_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      duty_s_q   <= duty_s_d;
      duty_a_q   <= duty_a_d;
    end
  end

`ifdef PWM_IRQ_EN
  logic irq_en_q, irq_en_d, wrap_flag_q, wrap_flag_d, irq_q, irq_d;
  assign irq_en    = irq_en_q;
  assign wrap_flag = wrap_flag_q;
  assign irq       = irq_q;

  // wrap sticky flag with write-1-to-clear; a coincident wrap wins over the clear
  always_comb begin
    irq_en_d    = (wr && word == 6'd0 && wstrb[0]) ? wdata[1] : irq_en_q;
    wrap_flag_d = wrap | (wrap_flag_q & ~(wr && word == 6'd3 && wstrb[0] && wdata[0]));
    irq_d       = wrap_flag_d & irq_en_d;
  end

  // status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_q    <= 1'b0;
      wrap_flag_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      irq_en_q    <= irq_en_d;
      wrap_flag_q <= wrap_flag_d;
      irq_q       <= irq_d;
    end
  end
`else
  assign irq_en    = 1'b0;
  assign wrap_flag = 1'b0;
  assign irq       = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed stimulus against a cycle-level behavioural model of pwm_multi_channel
`timescale 1ns/1ps
module tb_pwm_multi_channel;
  localparam int CH = 4;
  localparam int W = 16;
  localparam longint unsigned MASK = (64'd1 << W) - 1;

  logic          clk = 1'b0, reset = 1'b1, valid = 1'b0;
  logic [7:0]    addr = 8'd0;
  logic [3:0]    wstrb = 4'd0;
  logic [31:0]   wdata = 32'd0;
  logic          ready, irq;
  logic [31:0]   rdata;
  logic [CH-1:0] pwm_out;

  int checks = 0, errors = 0;
  bit chk_on = 1'b0;
  int cyc = 0;
  logic [CH-1:0] hist [8192];

  always #5 clk = ~clk;

  pwm_multi_channel #(.CHANNELS(CH), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .valid(valid), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .ready(ready), .rdata(rdata), .pwm_out(pwm_out), .irq(irq)
  );

  // model state: architectural registers as plain numbers
  longint unsigned m_cnt, m_pa, m_ps;
  longint unsigned m_da [CH];
  longint unsigned m_ds [CH];
  bit m_en, m_irqen, m_wrapf, m_irq, m_ready;
  bit [CH-1:0] m_pol, m_pwm;
  logic [31:0] m_rdata;

  function automatic longint unsigned bmerge(longint unsigned cur, logic [3:0] s, logic [31:0] d);
    longint unsigned v;
    v = cur;
    for (int k = 0; k < 4; k++)
      if (s[k]) v = (v & ~(64'hFF << (8 * k))) | ({32'd0, d} & (64'hFF << (8 * k)));
    return v & MASK;
  endfunction

  function automatic logic [31:0] m_read(int w);
    if (w == 0) return {16'd0, 8'(m_pol), 6'd0, m_irqen, m_en};
    if (w == 1) return 32'(m_ps);
    if (w == 2) return 32'(m_cnt);
    if (w == 3) return {31'd0, m_wrapf};
    if (w >= 4 && w < 4 + CH) return 32'(m_ds[w - 4]);
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    bit acc, wr, wrap;
    int w;
    if (reset) begin
      m_cnt = 0; m_pa = 0; m_ps = 0; m_en = 0; m_irqen = 0; m_wrapf = 0; m_irq = 0;
      m_ready = 0; m_pol = '0; m_pwm = '0; m_rdata = 32'd0;
      for (int i = 0; i < CH; i++) begin m_da[i] = 0; m_ds[i] = 0; end
    end else begin
      acc = valid && !m_ready;
      wr = acc && wstrb != 4'd0;
      w = int'(addr) / 4;
      m_rdata = acc ? m_read(w) : 32'd0;
      wrap = m_en && m_cnt == m_pa;
      for (int i = 0; i < CH; i++) m_pwm[i] = (m_en && m_cnt < m_da[i]) ^ m_pol[i];
      m_cnt = m_en ? (m_cnt + 1) % (m_pa + 1) : 0;
      if (wrap || !m_en) begin
        m_pa = m_ps;
        for (int i = 0; i < CH; i++) m_da[i] = m_ds[i];
      end
`ifdef PWM_IRQ_EN
      m_wrapf = wrap || (m_wrapf && !(wr && w == 3 && wstrb[0] && wdata[0]));
      if (wr && w == 0 && wstrb[0]) m_irqen = wdata[1];
      m_irq = m_wrapf && m_irqen;
`endif
      if (wr && w == 0 && wstrb[0]) m_en = wdata[0];
      if (wr && w == 0 && wstrb[1]) m_pol = wdata[8 +: CH];
      if (wr && w == 1) m_ps = bmerge(m_ps, wstrb, wdata);
      for (int i = 0; i < CH; i++) if (wr && w == 4 + i) m_ds[i] = bmerge(m_ds[i], wstrb, wdata);
      m_ready = acc;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < 8192) hist[cyc] = pwm_out;
    cyc++;
    if (chk_on) begin
      cmp("ready", 32'(ready), 32'(m_ready));
      if (m_ready) cmp("rdata", rdata, m_rdata);
      cmp("pwm_out", 32'(pwm_out), 32'(m_pwm));
      cmp("irq", 32'(irq), 32'(m_irq));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic bus(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] r);
    int k;
    valid = 1'b1; addr = a; wstrb = s; wdata = d; r = 32'd0;
    for (k = 0; k < 6; k++) begin
      tick();
      if (ready === 1'b1) break;
    end
    valid = 1'b0; wstrb = 4'd0;
    if (k == 6) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr %h: no ready in 6 cycles, ready required", a);
    end else r = rdata;
  endtask

  function automatic int hsum(int a, int n, int ch);
    int t;
    t = 0;
    for (int i = 0; i < n; i++) t += int'(hist[a + i][ch]);
    return t;
  endfunction

  task automatic find_rise(output int s);
    s = -1;
    for (int k = 0; k < 40 && s < 0; k++) begin
      tick();
      if (hist[cyc - 1][0] && !hist[cyc - 2][0]) s = cyc - 1;
    end
    if (s < 0) begin
      checks++; errors++;
      $display("FAIL rise_timeout: no rising edge on ch0 in 40 cycles, edge required");
      s = cyc - 1;
    end
  endtask

  initial begin
    logic [31:0] r;
    int s, c, c1;
    reset = 1'b1;
    tick(2);
    chk_on = 1'b1;
    tick();
    reset = 1'b0;
    cmp("rst_pwm", 32'(pwm_out), 32'd0);
    cmp("rst_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 4 + CH; i++) begin
      bus(8'(4 * i), 4'd0, 32'd0, r);
      cmp("rst_read", r, 32'd0);
    end
    bus(8'h40, 4'd0, 32'd0, r); cmp("unmapped_read", r, 32'd0);

    bus(8'h04, 4'hF, 32'd9, r);
    bus(8'h10, 4'hF, 32'd3, r);
    bus(8'h14, 4'hF, 32'd0, r);
    bus(8'h18, 4'hF, 32'd10, r);
    bus(8'h40, 4'hF, 32'hFFFF, r);
    bus(8'h04, 4'd0, 32'd0, r); cmp("unmapped_write_dropped", r, 32'd9);
    bus(8'h00, 4'hF, 32'd1, r);
    tick(25); c = cyc; tick(10);
    cmp("ch0_high_of_10", 32'(hsum(c, 10, 0)), 32'd3);
    cmp("ch1_high_of_10", 32'(hsum(c, 10, 1)), 32'd0);
    cmp("ch2_high_of_10", 32'(hsum(c, 10, 2)), 32'd10);
    bus(8'h08, 4'd0, 32'd0, r); c1 = int'(r);
    bus(8'h08, 4'd0, 32'd0, r);
    cmp("count_step", 32'((int'(r) + 10 - c1) % 10), 32'd2);
    cmp("count_range", 32'(r < 32'd10), 32'd1);

    bus(8'h00, 4'hF, 32'h100, r);
    tick(3);
    cmp("pol_idle_ch0", 32'(pwm_out[0]), 32'd1);
    bus(8'h08, 4'd0, 32'd0, r); cmp("count_idle", r, 32'd0);
    bus(8'h00, 4'hF, 32'h101, r);
    tick(25); c = cyc; tick(10);
    cmp("pol_ch0_high_of_10", 32'(hsum(c, 10, 0)), 32'd7);
    cmp("pol_ch2_high_of_10", 32'(hsum(c, 10, 2)), 32'd10);

    bus(8'h00, 4'hF, 32'h1, r);
    tick(12);
    find_rise(s);
    tick(4);
    bus(8'h10, 4'hF, 32'd7, r);
    while (cyc <= s + 20) tick();
    cmp("dutychg_cur_period", 32'(hsum(s, 10, 0)), 32'd3);
    cmp("dutychg_next_period", 32'(hsum(s + 10, 10, 0)), 32'd7);

    tick(3);
    find_rise(s);
    tick(8);
    bus(8'h10, 4'hF, 32'd2, r);
    while (cyc <= s + 30) tick();
    cmp("defer_p0", 32'(hsum(s, 10, 0)), 32'd7);
    cmp("defer_p1", 32'(hsum(s + 10, 10, 0)), 32'd7);
    cmp("defer_p2", 32'(hsum(s + 20, 10, 0)), 32'd2);

    bus(8'h04, 4'hF, 32'd0, r);
    tick(15);
    bus(8'h08, 4'd0, 32'd0, r); cmp("count_period0_a", r, 32'd0);
    bus(8'h08, 4'd0, 32'd0, r); cmp("count_period0_b", r, 32'd0);
    cmp("period0_ch0", 32'(pwm_out[0]), 32'd1);
    cmp("period0_ch1", 32'(pwm_out[1]), 32'd0);

    bus(8'h00, 4'hF, 32'd0, r);
    bus(8'h04, 4'hF, 32'h0000FFFF, r);
    bus(8'h04, 4'b0010, 32'h0000AB00, r);
    bus(8'h04, 4'd0, 32'd0, r); cmp("byte_write", r, 32'h0000ABFF);
    bus(8'h04, 4'hF, 32'hFFFFFFFF, r);
    bus(8'h04, 4'd0, 32'd0, r); cmp("width_trunc", r, 32'h0000FFFF);
    bus(8'h00, 4'b0010, 32'h00000F01, r);
    bus(8'h00, 4'd0, 32'd0, r); cmp("ctrl_byte1_only", r, 32'h00000F00);

    bus(8'h00, 4'hF, 32'd0, r);
    bus(8'h04, 4'hF, 32'd4, r);
    tick(2);
`ifdef PWM_IRQ_EN
    bus(8'h00, 4'hF, 32'd3, r);
    tick(4); cmp("irq_before_wrap", 32'(irq), 32'd0);
    tick(1); cmp("irq_after_wrap", 32'(irq), 32'd1);
    bus(8'h0C, 4'hF, 32'd1, r); cmp("irq_cleared", 32'(irq), 32'd0);
    tick(3); cmp("irq_still_clear", 32'(irq), 32'd0);
    tick(1); cmp("irq_next_wrap", 32'(irq), 32'd1);
    bus(8'h0C, 4'd0, 32'd0, r); cmp("status_wrap", r, 32'd1);
`else
    bus(8'h00, 4'hF, 32'd3, r);
    bus(8'h00, 4'd0, 32'd0, r); cmp("irq_en_readonly", r, 32'd1);
    tick(20);
    bus(8'h0C, 4'd0, 32'd0, r); cmp("status_zero", r, 32'd0);
    cmp("irq_off", 32'(irq), 32'd0);
`endif

    valid = 1'b1; addr = 8'h00; wstrb = 4'd0; reset = 1'b1;
    tick();
    cmp("reset_drops_access", 32'(ready), 32'd0);
    tick();
    valid = 1'b0; reset = 1'b0;
    tick();
    bus(8'h00, 4'd0, 32'd0, r); cmp("reset_ctrl", r, 32'd0);
    bus(8'h04, 4'd0, 32'd0, r); cmp("reset_period", r, 32'd0);
    bus(8'h08, 4'd0, 32'd0, r); cmp("reset_count", r, 32'd0);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Multi-channel PWM generator and the successor to the single-channel PWM in the user project. It runs one shared period counter and drives CHANNELS independent duty-cycle outputs. All configuration goes through the Wishbone-derived valid/ready register port already used in `user_proj_example`. Duty and period writes are double-buffered and take effect only at a period boundary, so outputs never glitch mid-period.

## Interface
Parameters:
- CHANNELS, 4, number of PWM outputs (1..8).
- CNT_W, 16, width of the counter, period and duty values (2..32).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid  in  1  bus request, held high until ready.
- addr  in  8  byte address; bits [1:0] are ignored.
- wstrb  in  4  byte write strobes; 0000 means a read.
- wdata  in  32  write data.
- ready  out  1  one-cycle acknowledge.
- rdata  out  32  read data, valid while ready=1.
- pwm_out  out  CHANNELS  PWM outputs, registered.
- irq  out  1  period interrupt; tied to 0 unless PWM_IRQ_EN is defined.

## Operation
Register map (32-bit words; unused bits read 0):
- 0x00 CTRL (RW):
  - bit0 EN: enable the counter.
  - bit1 IRQ_EN: enable the interrupt.
  - bits[8+:CHANNELS] POL: per-channel output inversion.
- 0x04 PERIOD (RW, shadow): the counter counts 0..PERIOD, so one period lasts PERIOD+1 cycles.
- 0x08 COUNT (RO): current counter value.
- 0x0C STATUS (read; write 1 to clear): bit0 WRAP.
- 0x10+4·i DUTY[i] (RW, shadow), for i < CHANNELS.
- Any other address: writes are dropped, reads return 0, and ready is still returned.

Byte writes: each wstrb[k] updates byte k of the target register. Bits at or above CNT_W are discarded.

Shadow scheme:
- Bus writes land in the shadow PERIOD_S and DUTY_S[i] registers, and reads return the shadow values.
- The active registers PERIOD_A and DUTY_A[i] load from the shadows:
  - on every cycle where the wrap condition holds (EN=1 and count==PERIOD_A), and
  - on every cycle while EN=0.

Counter:
- While EN=0, count is held at 0.
- While EN=1, count increments each cycle.
- When count==PERIOD_A, count wraps to 0.
- When PERIOD_A=0, count stays at 0 and a wrap occurs every cycle.

Output:
- raw[i] = EN & (count < DUTY_A[i]), as an unsigned CNT_W-bit compare.
- pwm_out[i] <= raw[i] ^ POL[i], registered.
- DUTY_A[i]=0 gives a constant inactive level.
- DUTY_A[i] > PERIOD_A gives a constant active level (100%).
- While EN=0, pwm_out equals POL (the inactive level).

## Timing
- Reset values:
  - count, CTRL, PERIOD_S/A, DUTY_S/A and STATUS are all 0.
  - pwm_out=0, ready=0, rdata=0, irq=0.
- Bus handshake:
  - When valid=1 and ready=0, the block responds with ready=1 on the next cycle.
  - The write is applied, or rdata is captured, in that same cycle.
  - ready is then forced to 0 for one cycle, so a held valid produces exactly one access per two cycles.
- Write latency: a write is visible on read-back in the cycle after ready.
- Output latency: pwm_out lags count by one cycle.
- A CTRL.EN write of 1 starts the counter from 0 one cycle later.
- Simultaneous shadow write and wrap:
  - The active registers load the pre-write shadow value.
  - The new value takes effect at the following wrap.
- Clearing EN mid-period: count goes to 0 and pwm_out goes to POL on the next cycle. The active registers then follow the shadows.
- reset asserted mid-operation:
  - Everything returns to reset values on the next edge.
  - A pending bus access is dropped with no ready.

## Configuration
- PWM_IRQ_EN defined:
  - STATUS.WRAP is set on every wrap cycle.
  - Writing 1 to STATUS bit0 clears WRAP. If the clear coincides with a wrap, the set wins.
  - irq = WRAP & IRQ_EN, registered.
- PWM_IRQ_EN undefined:
  - STATUS reads 0, IRQ_EN is read-only 0, and irq is constant 0.
  - No status logic is synthesised.

## Test plan
- Reset, then read all registers:
  - every register reads 0; pwm_out=0; irq=0.
  - each access returns exactly one ready pulse.
- PERIOD=9, DUTY[0]=3, DUTY[1]=0, DUTY[2]=10, EN=1:
  - ch0 is high for 3 of every 10 cycles.
  - ch1 is constantly low and ch2 is constantly high.
  - COUNT cycles 0..9.
- POL=0b0001 with EN=0 -> pwm_out[0]=1. After EN=1 and DUTY[0]=3 -> ch0 is low for 3 and high for 7 of every 10 cycles.
- While running with DUTY[0]=3, write DUTY[0]=7 when count=5:
  - the current period stays at 3 high cycles.
  - the next period shows 7 high cycles.
  - a write landing exactly on count==PERIOD_A is deferred one more period.
- A byte write with wstrb=0010 and wdata=0x0000AB00 to PERIOD (0x0000FFFF) -> reads back 0x0000ABFF.
- With PWM_IRQ_EN, PERIOD=4, IRQ_EN=1:
  - irq rises one cycle after the first wrap.
  - a write of 1 to STATUS clears irq until the next wrap.
  - without the macro, irq stays at 0 throughout.
